// File: rtl/alu_issue_unit.sv
// Issue stage in front of a combinational ALU. S1 registers the request and drives the ALU.
// S2 captures the ALU result and returns it to the consumer.
module alu_issue_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_illegal,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1010;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;
    logic             s1_illegal;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic             s2_zero;
    logic             s2_illegal;

    logic accept;
    logic s2_free;
    logic s1_move;
    logic in_illegal;

    always_comb begin
        in_illegal = 1'b1;
        case (in_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT: in_illegal = 1'b0;
            default: in_illegal = 1'b1;
        endcase
    end

    // Both handshakes: a transfer happens on a rising edge where valid && ready; the
    // sender holds its payload stable while valid is high and ready is low.
    assign s2_free  = !s2_valid || res_ready;
    assign s1_move  = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    assign alu_a  = s1_a;
    assign alu_b  = s1_b;
    assign alu_op = s1_illegal ? 4'b0000 : s1_op;

    assign res_valid   = s2_valid;
    assign res_data    = s2_data;
    assign res_zero    = s2_zero;
    assign res_illegal = s2_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= 4'b0000;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_a       <= in_a;
            s1_b       <= in_b;
            s1_op      <= in_op;
            s1_illegal <= in_illegal;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // Illegal requests still flow through S2 so the consumer sees them in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_zero    <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (s1_move) begin
            s2_valid   <= 1'b1;
            s2_data    <= s1_illegal ? '0 : alu_out;
            s2_zero    <= s1_illegal ? 1'b0 : alu_zero;
            s2_illegal <= s1_illegal;
        end else if (s2_valid && res_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt  <= '0;
            illegal_cnt <= '0;
        end else if (accept) begin
            if (issued_cnt != '1) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            if (in_illegal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end
    end

endmodule
